// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared dmem op codes, owner encoding and response tag type
package dmem_arb_pkg;

    // Memory op codes presented by requesters and driven onto the shared dmem port
    localparam logic [2:0] MEM_OP_NONE = 3'd0;
    localparam logic [2:0] MEM_OP_LB   = 3'd1;
    localparam logic [2:0] MEM_OP_LH   = 3'd2;
    localparam logic [2:0] MEM_OP_LW   = 3'd3;
    localparam logic [2:0] MEM_OP_LBU  = 3'd4;
    localparam logic [2:0] MEM_OP_SB   = 3'd5;
    localparam logic [2:0] MEM_OP_SH   = 3'd6;
    localparam logic [2:0] MEM_OP_SW   = 3'd7;

    // Which requester a pending read response belongs to
    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DBG = 1'b1
    } owner_e;

    // Tag for the single outstanding read (memory latency is one cycle)
    typedef struct packed {
        logic   valid;
        owner_e owner;
    } resp_tag_t;

    function automatic logic op_is_write(input logic [2:0] op);
        return (op == MEM_OP_SB) || (op == MEM_OP_SH) || (op == MEM_OP_SW);
    endfunction

    function automatic logic op_is_read(input logic [2:0] op);
        return (op != MEM_OP_NONE) && !op_is_write(op);
    endfunction

endpackage

// File: rtl/dmem_arb_if.sv
// rtl/dmem_arb_if.sv - requester-side dmem access port
interface dmem_arb_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic [2:0]        op;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    // Requester side: presents the access, receives grant and read data
    modport master (
        output req, op, addr, wdata,
        input  gnt, rvalid, rdata
    );

    // Arbiter side
    modport slave (
        input  req, op, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/dmem_arb_resp.sv
// rtl/dmem_arb_resp.sv - read response tag register and rvalid/rdata routing
module dmem_arb_resp
    import dmem_arb_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_issue,
    input  owner_e            rd_owner,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              cpu_rvalid,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [DATA_W-1:0] dbg_rdata
);

    resp_tag_t tag_q;
    resp_tag_t tag_d;

    // Load the tag on every granted read; a new read can follow immediately
    always_comb begin
        tag_d.valid = rd_issue;
        tag_d.owner = rd_issue ? rd_owner : tag_q.owner;
    end

    // Tag register; reset drops any read issued just before reset
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_q <= '{valid: 1'b0, owner: OWN_CPU};
        end else begin
            tag_q <= tag_d;
        end
    end

    // Route the returning data to exactly the requester that issued the read
    always_comb begin
        cpu_rvalid = !rst && tag_q.valid && (tag_q.owner == OWN_CPU);
        dbg_rvalid = !rst && tag_q.valid && (tag_q.owner == OWN_DBG);
        cpu_rdata  = mem_rdata;
        dbg_rdata  = mem_rdata;
    end

endmodule

// File: rtl/dmem_arb.sv
// rtl/dmem_arb.sv - CPU/debug arbiter in front of the shared data memory port
module dmem_arb
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_LIM = 4
) (
    input  logic              clk,
    input  logic              rst,
    dmem_arb_if.slave         cpu,
    dmem_arb_if.slave         dbg,
    output logic              cpu_stall,
    output logic [2:0]        mem_op,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int SCW = $clog2(STARVE_LIM + 1);

    logic [SCW-1:0]    starve_cnt_q;
    logic [SCW-1:0]    starve_cnt_d;
    logic              cpu_valid;
    logic              dbg_valid;
    logic              starved;
    logic              dbg_win;
    logic              cpu_gnt;
    logic              dbg_gnt;
    logic              rd_issue;
    owner_e            rd_owner;
    logic              cpu_rvalid;
    logic              dbg_rvalid;
    logic [DATA_W-1:0] cpu_rdata;
    logic [DATA_W-1:0] dbg_rdata;

    // Qualify requests and pick a winner: CPU first unless debug has waited too long
    always_comb begin
        cpu_valid = cpu.req && (cpu.op != MEM_OP_NONE);
        dbg_valid = dbg.req && (dbg.op != MEM_OP_NONE);
        starved   = (starve_cnt_q >= SCW'(STARVE_LIM));
        dbg_win   = dbg_valid && (!cpu_valid || starved);
        cpu_gnt   = !rst && cpu_valid && !dbg_win;
        dbg_gnt   = !rst && dbg_win;
        cpu_stall = !rst && cpu_valid && !cpu_gnt;
    end

    // Drive the shared port from the granted requester in the same cycle
    always_comb begin
        mem_op    = MEM_OP_NONE;
        mem_addr  = cpu.addr;
        mem_wdata = cpu.wdata;
        if (dbg_gnt) begin
            mem_op    = dbg.op;
            mem_addr  = dbg.addr;
            mem_wdata = dbg.wdata;
        end else if (cpu_gnt) begin
            mem_op = cpu.op;
        end
    end

    // Count consecutive cycles the debug request is denied, saturating at the limit
    always_comb begin
        starve_cnt_d = '0;
        if (dbg_valid && !dbg_gnt) begin
            starve_cnt_d = starved ? starve_cnt_q : starve_cnt_q + SCW'(1);
        end
    end

    // Starvation counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // Note which requester owns a read issued this cycle
    always_comb begin
        rd_issue = (cpu_gnt && op_is_read(cpu.op)) || (dbg_gnt && op_is_read(dbg.op));
        rd_owner = dbg_gnt ? OWN_DBG : OWN_CPU;
    end

    dmem_arb_resp #(
        .DATA_W (DATA_W)
    ) u_resp (
        .clk        (clk),
        .rst        (rst),
        .rd_issue   (rd_issue),
        .rd_owner   (rd_owner),
        .mem_rdata  (mem_rdata),
        .cpu_rvalid (cpu_rvalid),
        .dbg_rvalid (dbg_rvalid),
        .cpu_rdata  (cpu_rdata),
        .dbg_rdata  (dbg_rdata)
    );

    assign cpu.gnt    = cpu_gnt;
    assign dbg.gnt    = dbg_gnt;
    assign cpu.rvalid = cpu_rvalid;
    assign dbg.rvalid = dbg_rvalid;
    assign cpu.rdata  = cpu_rdata;
    assign dbg.rdata  = dbg_rdata;

endmodule
